game_speed_ctrl: RTL

Parametrised game-speed controller: decodes a rotary encoder (quadrature A/B plus push switch) into a saturating speed level, and generates the game tick from the system clock. Generalises the fixed 4-level encoder/divider pair: it adds input synchronisation, per-input debounce, proper A/B direction decoding, and N levels. Its output is a single-cycle clock enable (`tick`) in the `I_CLK` domain, plus a legacy square wave. Sits between the board encoder pins and the game-logic/snake-movement FSM.

---
 rtl/game_speed_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/game_speed_ctrl.sv
// Rotary-encoder speed controller: synchronises and debounces A/B/switch, decodes
// detent direction into a saturating level, and divides I_CLK into a game tick enable.
module game_speed_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LEVELS       = 4,
  parameter int LVL_W        = 2,
  parameter int BASE_DIV     = 20000000,
  parameter int DIV_W        = 32
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             sia,
  input  logic             sib,
  input  logic             sw,
  output logic [LVL_W-1:0] level,
  output logic             tick,
  output logic             clk_game
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  // Channel index: 0 = A, 1 = B, 2 = switch (active-low, idles high).
  localparam logic [2:0] IDLE = 3'b100;

  logic [SYNC_STAGES-1:0] sync_a, sync_b, sync_s;
  logic [2:0]             syn;
  logic [2:0]             deb;
  logic [DB_W-1:0]        db_cnt [3];

  logic                   a_prev;
  logic                   a_rise;
  logic [LVL_W-1:0]       level_nxt;
  logic                   level_chg;

  logic [DIV_W-1:0]       div_shift;
  logic [DIV_W-1:0]       div;
  logic [DIV_W-1:0]       div_cnt;

  always_ff @(posedge I_CLK or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      sync_s <= '1;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], sia};
      sync_b <= {sync_b[SYNC_STAGES-2:0], sib};
      sync_s <= {sync_s[SYNC_STAGES-2:0], sw};
    end
  end

  always_comb begin
    syn = {sync_s[SYNC_STAGES-1], sync_b[SYNC_STAGES-1], sync_a[SYNC_STAGES-1]};
  end

  // The cycle that completes DEBOUNCE_CYC differing samples commits the new value,
  // so a pulse exactly DEBOUNCE_CYC cycles long is accepted.
  always_ff @(posedge I_CLK or posedge rst) begin
    if (rst) begin
      deb <= IDLE;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (syn[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          deb[i]    <= syn[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    a_rise    = deb[0] & ~a_prev;
    level_nxt = level;
    if (!deb[2]) begin
      level_nxt = '0;
    end else if (a_rise) begin
      if (!deb[1]) begin
        if (level != LVL_W'(LEVELS - 1)) level_nxt = level + 1'b1;
      end else begin
        if (level != '0) level_nxt = level - 1'b1;
      end
    end
    level_chg = (level_nxt != level);
  end

  always_comb begin
    div_shift = DIV_W'(BASE_DIV) >> level;
    div       = (div_shift == '0) ? DIV_W'(1) : div_shift;
  end

  always_ff @(posedge I_CLK or posedge rst) begin
    if (rst) begin
      a_prev   <= 1'b0;
      level    <= '0;
      div_cnt  <= '0;
      tick     <= 1'b0;
      clk_game <= 1'b0;
    end else begin
      a_prev <= deb[0];
      level  <= level_nxt;
      if (level_chg) begin
        div_cnt <= '0;
        tick    <= 1'b0;
      end else if (div_cnt == div - 1'b1) begin
        div_cnt  <= '0;
        tick     <= 1'b1;
        clk_game <= ~clk_game;
      end else begin
        div_cnt <= div_cnt + 1'b1;
        tick    <= 1'b0;
      end
    end
  end

endmodule
